sdr_lbus_master: RTL and testbench

Host-side front end for the SDR SDRAM controller's local bus. Accepts one read or write command at a time on a valid/ready command channel and buffers write data in a FIFO. It drives R_REQ/W_REQ/RADDR/B_SIZE/AUTO_PCH until RW_ACK, feeds write words on D_REQ and returns read beats with a last-beat marker. It sits directly upstream of the controller top level and owns all local-bus handshake rules, so the host never has to meet D_REQ/R_VALID timing itself.

---
 rtl/sdr_lbus_pkg.sv | 14 +
 rtl/sdr_wfifo.sv | 62 ++++++
 rtl/sdr_lbus_master.sv | 207 ++++++++++++++++++++
 tb/tb_sdr_lbus_master.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_lbus_pkg.sv
// Shared types and constants for the SDR SDRAM local-bus master front end.
package sdr_lbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WD = 2'd1,
        ST_REQ     = 2'd2,
        ST_DATA    = 2'd3
    } state_e;

    localparam int BEAT_W          = 4;
    localparam int MIN_WFIFO_DEPTH = 15;

endpackage

// File: rtl/sdr_wfifo.sv
// Synchronous write-data FIFO with occupancy count; push-when-full and
// pop-when-empty are ignored so the caller only has to watch full/empty.
module sdr_wfifo #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly AW bits wide, so the increment wraps modulo depth.
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok) count_d = count_q + 1'b1;
        if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed behind a nonzero count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/sdr_lbus_master.sv
// Host-side local-bus master: one command at a time, write data staged in a
// FIFO so D_REQ never underruns, read beats forwarded with a last marker.
module sdr_lbus_master
    import sdr_lbus_pkg::*;
#(
    parameter int SDRAM_RASIZE = 31,
    parameter int DATA_WIDTH   = 32,
    parameter int WFIFO_AWIDTH = 4   // depth 2**WFIFO_AWIDTH must be >= MIN_WFIFO_DEPTH
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    // Host command channel: transfer when CMD_VALID && CMD_READY at a rising edge.
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_WRITE,
    input  logic [SDRAM_RASIZE-1:0] CMD_ADDR,
    input  logic [BEAT_W-1:0]       CMD_BSIZE,
    input  logic                    CMD_APCH,
    input  logic                    WD_VALID,
    output logic                    WD_READY,
    input  logic [DATA_WIDTH-1:0]   WD_DATA,
    output logic                    RD_VALID,
    output logic [DATA_WIDTH-1:0]   RD_DATA,
    output logic                    RD_LAST,
    output logic                    ERR,
    // Controller side
    output logic [SDRAM_RASIZE-1:0] RADDR,
    output logic                    R_REQ,
    output logic                    W_REQ,
    output logic                    AUTO_PCH,
    output logic [BEAT_W-1:0]       B_SIZE,
    input  logic                    RW_ACK,
    input  logic                    D_REQ,
    input  logic                    W_VALID,
    input  logic                    R_VALID,
    output logic [DATA_WIDTH-1:0]   SDR_WDATA,
    input  logic [DATA_WIDTH-1:0]   SDR_RDATA,
    // Debug visibility
    output state_e                  DBG_STATE,
    output logic [WFIFO_AWIDTH:0]   DBG_WFIFO_COUNT
);

    state_e                  state_q, state_d;
    logic [SDRAM_RASIZE-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0]       bsize_q, bsize_d;
    logic                    apch_q, apch_d;
    logic                    write_q, write_d;
    logic [BEAT_W-1:0]       beats_q, beats_d;
    logic                    r_req_q, r_req_d;
    logic                    w_req_q, w_req_d;
    logic [DATA_WIDTH-1:0]   sdr_wdata_q, sdr_wdata_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_last_q, rd_last_d;
    logic                    err_q, err_d;

    logic                    fifo_pop;
    logic [DATA_WIDTH-1:0]   fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [WFIFO_AWIDTH:0]   fifo_count;
    logic                    in_wr_data;
    logic                    in_rd_data;
    logic                    beat;
    logic                    err_evt;

    sdr_wfifo #(
        .DW (DATA_WIDTH),
        .AW (WFIFO_AWIDTH)
    ) u_wfifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (WD_VALID),
        .wdata (WD_DATA),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign CMD_READY       = (state_q == ST_IDLE);
    assign WD_READY        = !fifo_full;
    assign RADDR           = addr_q;
    assign B_SIZE          = bsize_q;
    assign AUTO_PCH        = apch_q;
    assign R_REQ           = r_req_q;
    assign W_REQ           = w_req_q;
    assign SDR_WDATA       = sdr_wdata_q;
    assign RD_DATA         = rd_data_q;
    assign RD_VALID        = rd_valid_q;
    assign RD_LAST         = rd_last_q;
    assign ERR             = err_q;
    assign DBG_STATE       = state_q;
    assign DBG_WFIFO_COUNT = fifo_count;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bsize_d     = bsize_q;
        apch_d      = apch_q;
        write_d     = write_q;
        beats_d     = beats_q;
        r_req_d     = r_req_q;
        w_req_d     = w_req_q;
        sdr_wdata_d = sdr_wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        fifo_pop    = 1'b0;
        err_evt     = 1'b0;

        in_wr_data = (state_q == ST_DATA) && write_q;
        in_rd_data = (state_q == ST_DATA) && !write_q;
        beat       = write_q ? D_REQ : R_VALID;

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    if (CMD_BSIZE == '0) begin
                        err_evt = 1'b1;
                    end else begin
                        addr_d  = CMD_ADDR;
                        bsize_d = CMD_BSIZE;
                        apch_d  = CMD_APCH;
                        write_d = CMD_WRITE;
                        r_req_d = !CMD_WRITE;
                        state_d = CMD_WRITE ? ST_WAIT_WD : ST_REQ;
                    end
                end
            end
            ST_WAIT_WD: begin
                // The whole burst must be queued first: D_REQ cannot be stalled.
                if (fifo_count >= {1'b0, bsize_q}) begin
                    w_req_d = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (RW_ACK) begin
                    r_req_d = 1'b0;
                    w_req_d = 1'b0;
                    beats_d = bsize_q;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    beats_d = beats_q - 1'b1;
                    if (beats_q == BEAT_W'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (D_REQ) begin
            if (in_wr_data && !fifo_empty) fifo_pop = 1'b1;
            else                           err_evt  = 1'b1;
        end
        if (fifo_pop) sdr_wdata_d = fifo_rdata;

        // Read beats are always forwarded, even stray ones, since they cannot be refused.
        if (R_VALID) begin
            rd_valid_d = 1'b1;
            rd_data_d  = SDR_RDATA;
            rd_last_d  = in_rd_data && (beats_q == BEAT_W'(1));
            if (!in_rd_data) err_evt = 1'b1;
        end

        if (W_VALID && !in_wr_data) err_evt = 1'b1;

        err_d = err_q || err_evt;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            bsize_q     <= '0;
            apch_q      <= 1'b0;
            write_q     <= 1'b0;
            beats_q     <= '0;
            r_req_q     <= 1'b0;
            w_req_q     <= 1'b0;
            sdr_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bsize_q     <= bsize_d;
            apch_q      <= apch_d;
            write_q     <= write_d;
            beats_q     <= beats_d;
            r_req_q     <= r_req_d;
            w_req_q     <= w_req_d;
            sdr_wdata_q <= sdr_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_sdr_lbus_master.sv
// Directed bench for sdr_lbus_master: reset, read burst, write bursts,
// FIFO threshold wait, error cases and mid-burst reset.
module tb_sdr_lbus_master;
    import sdr_lbus_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CMD_VALID, CMD_READY, CMD_WRITE, CMD_APCH;
    logic [30:0] CMD_ADDR;
    logic [3:0]  CMD_BSIZE;
    logic        WD_VALID, WD_READY;
    logic [31:0] WD_DATA;
    logic        RD_VALID, RD_LAST, ERR;
    logic [31:0] RD_DATA;
    logic [30:0] RADDR;
    logic        R_REQ, W_REQ, AUTO_PCH;
    logic [3:0]  B_SIZE;
    logic        RW_ACK, D_REQ, W_VALID, R_VALID;
    logic [31:0] SDR_WDATA, SDR_RDATA;
    state_e      dbg_state;
    logic [4:0]  dbg_count;

    int n_checks = 0;
    int n_errors = 0;

    sdr_lbus_master dut (
        .CLK (CLK), .RESET_N (RESET_N),
        .CMD_VALID (CMD_VALID), .CMD_READY (CMD_READY), .CMD_WRITE (CMD_WRITE),
        .CMD_ADDR (CMD_ADDR), .CMD_BSIZE (CMD_BSIZE), .CMD_APCH (CMD_APCH),
        .WD_VALID (WD_VALID), .WD_READY (WD_READY), .WD_DATA (WD_DATA),
        .RD_VALID (RD_VALID), .RD_DATA (RD_DATA), .RD_LAST (RD_LAST), .ERR (ERR),
        .RADDR (RADDR), .R_REQ (R_REQ), .W_REQ (W_REQ), .AUTO_PCH (AUTO_PCH),
        .B_SIZE (B_SIZE), .RW_ACK (RW_ACK), .D_REQ (D_REQ), .W_VALID (W_VALID),
        .R_VALID (R_VALID), .SDR_WDATA (SDR_WDATA), .SDR_RDATA (SDR_RDATA),
        .DBG_STATE (dbg_state), .DBG_WFIFO_COUNT (dbg_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        WD_VALID = 1'b1;
        WD_DATA  = d;
        step();
        WD_VALID = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [30:0] a, input logic [3:0] bs, input logic ap);
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = a;
        CMD_BSIZE = bs;
        CMD_APCH  = ap;
        step();
        CMD_VALID = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0;
        CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = '0; CMD_BSIZE = '0; CMD_APCH = 0;
        WD_VALID = 0; WD_DATA = '0;
        RW_ACK = 0; D_REQ = 0; W_VALID = 0; R_VALID = 0; SDR_RDATA = '0;
        step();
        step();

        // Reset values
        chk("rst_r_req", R_REQ, 0);
        chk("rst_w_req", W_REQ, 0);
        chk("rst_apch", AUTO_PCH, 0);
        chk("rst_rd_valid", RD_VALID, 0);
        chk("rst_rd_last", RD_LAST, 0);
        chk("rst_err", ERR, 0);
        chk("rst_raddr", RADDR, 0);
        chk("rst_bsize", B_SIZE, 0);
        chk("rst_sdr_wdata", SDR_WDATA, 0);
        chk("rst_rd_data", RD_DATA, 0);
        chk("rst_cmd_ready", CMD_READY, 1);
        chk("rst_wd_ready", WD_READY, 1);

        RESET_N = 1'b1;
        step(); step(); step();
        chk("idle_reqs", {R_REQ, W_REQ, RD_VALID, ERR}, 4'b0000);
        chk("idle_state", dbg_state, ST_IDLE);

        // Read burst, ack three cycles after the request
        issue(1'b0, 31'h100, 4'd4, 1'b0);
        chk("rd_req_up", R_REQ, 1);
        chk("rd_raddr", RADDR, 31'h100);
        chk("rd_bsize", B_SIZE, 4);
        chk("rd_cmd_ready_low", CMD_READY, 0);
        step();
        step();
        chk("rd_req_held", R_REQ, 1);
        RW_ACK = 1'b1;
        step();
        RW_ACK = 1'b0;
        chk("rd_req_drop", R_REQ, 0);
        chk("rd_state_data", dbg_state, ST_DATA);
        for (int i = 0; i < 4; i++) begin
            R_VALID   = 1'b1;
            SDR_RDATA = 32'hA0 + i;
            step();
            chk("rd_valid", RD_VALID, 1);
            chk("rd_data", RD_DATA, 32'hA0 + i);
            chk("rd_last", RD_LAST, (i == 3));
        end
        R_VALID = 1'b0;
        chk("rd_back_idle", CMD_READY, 1);
        step();
        chk("rd_valid_drop", {RD_VALID, RD_LAST}, 2'b00);
        chk("rd_err", ERR, 0);

        // Write burst of 8 with auto-precharge and a D_REQ gap
        for (int i = 0; i < 8; i++) push_word(32'h10 + i);
        chk("wr_fifo_cnt", dbg_count, 8);
        issue(1'b1, 31'h200, 4'd8, 1'b1);
        chk("wr_wait_state", dbg_state, ST_WAIT_WD);
        chk("wr_wait_noreq", W_REQ, 0);
        step();
        chk("wr_req_up", W_REQ, 1);
        chk("wr_apch", AUTO_PCH, 1);
        chk("wr_bsize", B_SIZE, 8);
        chk("wr_raddr", RADDR, 31'h200);
        RW_ACK = 1'b1;
        step();
        RW_ACK = 1'b0;
        chk("wr_req_drop", W_REQ, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                D_REQ = 1'b0;
                step();
                chk("wr_gap_hold", SDR_WDATA, 32'h13);
            end
            D_REQ = 1'b1;
            step();
            chk("wr_data", SDR_WDATA, 32'h10 + i);
        end
        D_REQ = 1'b0;
        chk("wr_fifo_empty", dbg_count, 0);
        chk("wr_back_idle", dbg_state, ST_IDLE);
        chk("wr_err", ERR, 0);
        step();

        // Write waits for the FIFO to reach the burst length
        push_word(32'h20);
        push_word(32'h21);
        issue(1'b1, 31'h300, 4'd5, 1'b0);
        step();
        chk("thr_wait_state", dbg_state, ST_WAIT_WD);
        chk("thr_wait_noreq", W_REQ, 0);
        push_word(32'h22);
        push_word(32'h23);
        chk("thr_4_noreq", W_REQ, 0);
        push_word(32'h24);
        chk("thr_5_noreq", W_REQ, 0);
        step();
        chk("thr_req_up", W_REQ, 1);
        RW_ACK = 1'b1;
        step();
        RW_ACK = 1'b0;
        for (int i = 0; i < 5; i++) begin
            D_REQ = 1'b1;
            step();
            chk("thr_data", SDR_WDATA, 32'h20 + i);
        end
        D_REQ = 1'b0;
        chk("thr_back_idle", dbg_state, ST_IDLE);
        chk("thr_err", ERR, 0);
        step();

        // Zero-length command and stray controller strobes
        issue(1'b0, 31'h55, 4'd0, 1'b0);
        chk("z_err", ERR, 1);
        chk("z_state", dbg_state, ST_IDLE);
        chk("z_cmd_ready", CMD_READY, 1);
        step();
        chk("z_noreq", {R_REQ, W_REQ}, 2'b00);
        D_REQ = 1'b1;
        step();
        D_REQ = 1'b0;
        chk("stray_dreq_err", ERR, 1);
        chk("stray_dreq_hold", SDR_WDATA, 32'h24);
        R_VALID   = 1'b1;
        SDR_RDATA = 32'h55;
        step();
        R_VALID = 1'b0;
        chk("stray_rv_valid", RD_VALID, 1);
        chk("stray_rv_data", RD_DATA, 32'h55);
        chk("stray_rv_last", RD_LAST, 0);
        chk("stray_rv_err", ERR, 1);
        step();

        // Reset in the middle of a write burst
        for (int i = 0; i < 8; i++) push_word(32'h30 + i);
        issue(1'b1, 31'h400, 4'd8, 1'b0);
        step();
        chk("mr_req_up", W_REQ, 1);
        RW_ACK = 1'b1;
        step();
        RW_ACK = 1'b0;
        for (int i = 0; i < 3; i++) begin
            D_REQ = 1'b1;
            step();
        end
        D_REQ = 1'b0;
        chk("mr_data3", SDR_WDATA, 32'h32);
        RESET_N = 1'b0;
        #1;
        chk("mr_w_req", W_REQ, 0);
        chk("mr_fifo_empty", dbg_count, 0);
        chk("mr_state", dbg_state, ST_IDLE);
        chk("mr_err_clr", ERR, 0);
        step();
        RESET_N = 1'b1;
        step();

        // Read after reset completes normally
        issue(1'b0, 31'h40, 4'd2, 1'b0);
        chk("pr_req_up", R_REQ, 1);
        RW_ACK = 1'b1;
        step();
        RW_ACK = 1'b0;
        chk("pr_req_drop", R_REQ, 0);
        R_VALID = 1'b1;
        SDR_RDATA = 32'hB0;
        step();
        chk("pr_beat0", {RD_VALID, RD_LAST, RD_DATA}, {1'b1, 1'b0, 32'hB0});
        SDR_RDATA = 32'hB1;
        step();
        R_VALID = 1'b0;
        chk("pr_beat1", {RD_VALID, RD_LAST, RD_DATA}, {1'b1, 1'b1, 32'hB1});
        chk("pr_idle", dbg_state, ST_IDLE);
        chk("pr_err", ERR, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
